// File: rtl/text_mem_pkg.sv
// Shared constants and types for the 40x15 text-mode character RAM.
package text_mem_pkg;

  localparam int unsigned TXT_COLS   = 40;
  localparam int unsigned TXT_ROWS   = 15;
  localparam int unsigned TXT_CELLS  = TXT_COLS * TXT_ROWS;
  localparam int unsigned TXT_ADDR_W = 10;
  localparam int unsigned TXT_DATA_W = 10;

  typedef enum logic {ARB_IDLE, ARB_CLEAR} arb_state_t;

  typedef logic [TXT_ADDR_W-1:0] txt_addr_t;

endpackage

// File: rtl/text_mem_arbiter_clear.sv
// Screen clear sequencer: sweeps addresses 0..CELLS-1, pausing whenever the
// port is taken by a VGA fetch. With TEXT_MEM_ARB_FILL_EN defined the fill
// value is captured from clr_fill on the starting clr_req; otherwise it is 0.
module text_clear_engine
  import text_mem_pkg::*;
#(
  parameter int unsigned CELLS  = TXT_CELLS,
  parameter int unsigned ADDR_W = TXT_ADDR_W,
  parameter int unsigned DATA_W = TXT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              hold,
`ifdef TEXT_MEM_ARB_FILL_EN
  input  logic [DATA_W-1:0] clr_fill,
`endif
  output arb_state_t        state,
  output logic [ADDR_W-1:0] cnt,
  output logic [DATA_W-1:0] fill,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CELLS - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // Next state: start on clr_req in idle (ignored mid-sweep), step unless held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (clr_req) begin
          state_d = ARB_CLEAR;
          cnt_d   = '0;
        end
      end
      ARB_CLEAR: begin
        if (!hold) begin
          if (cnt_q == LastAddr) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  // State, counter and done pulse registers; reset aborts a sweep silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef TEXT_MEM_ARB_FILL_EN
  logic [DATA_W-1:0] fill_q;

  // Capture the fill value only on a clr_req that actually starts a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else if (state_q == ARB_IDLE && clr_req) begin
      fill_q <= clr_fill;
    end
  end

  assign fill = fill_q;
`else
  assign fill = '0;
`endif

  assign state    = state_q;
  assign cnt      = cnt_q;
  assign clr_busy = (state_q == ARB_CLEAR);
  assign clr_done = done_q;

endmodule

// File: rtl/text_mem_arbiter.sv
// Single-port character RAM arbiter: VGA fetch > clear sweep > keyboard write,
// one grant per cycle. Optional macro TEXT_MEM_ARB_FILL_EN adds the clr_fill
// port selecting the sweep value.
module text_mem_arbiter
  import text_mem_pkg::*;
#(
  parameter int unsigned COLS   = TXT_COLS,
  parameter int unsigned ROWS   = TXT_ROWS,
  parameter int unsigned ADDR_W = TXT_ADDR_W,
  parameter int unsigned DATA_W = TXT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  input  logic              kb_req,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_data,
  output logic              kb_ack,
  output logic              kb_err,
  input  logic              clr_req,
`ifdef TEXT_MEM_ARB_FILL_EN
  input  logic [DATA_W-1:0] clr_fill,
`endif
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned CELLS = COLS * ROWS;

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              kb_oor;
  logic              vga_rd_valid_q;

  text_clear_engine #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .hold     (vga_rd_en),
`ifdef TEXT_MEM_ARB_FILL_EN
    .clr_fill (clr_fill),
`endif
    .state    (state),
    .cnt      (clr_cnt),
    .fill     (clr_val),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  assign kb_oor = 32'(kb_addr) >= CELLS;

  // Port mux and keyboard handshake; keyboard only gets idle, VGA-free cycles.
  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    kb_ack      = 1'b0;
    kb_err      = 1'b0;
    if (vga_rd_en) begin
      mem_addr = vga_rd_addr;
    end else if (state == ARB_CLEAR) begin
      mem_addr    = clr_cnt;
      mem_we      = 1'b1;
      mem_wr_data = clr_val;
    end else if (kb_req) begin
      mem_addr    = kb_addr;
      mem_wr_data = kb_data;
      mem_we      = !kb_oor;
      kb_ack      = 1'b1;
      kb_err      = kb_oor;
    end
  end

  // Read valid tracks the RAM's one-cycle latency after a VGA grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rd_valid_q <= 1'b0;
    end else begin
      vga_rd_valid_q <= vga_rd_en;
    end
  end

  // The RAM output register already holds the fetched word in the valid cycle.
  assign vga_rd_valid = vga_rd_valid_q;
  assign vga_rd_data  = vga_rd_valid_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Randomized bench for text_mem_arbiter against a cycle-level reference model
// of the grant rules, with a synchronous RAM model behind the port.
module tb_text_mem_arbiter;

  localparam int CELLS = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_rd_en;
  logic [9:0] vga_rd_addr;
  logic [9:0] vga_rd_data;
  logic       vga_rd_valid;
  logic       kb_req;
  logic [9:0] kb_addr;
  logic [9:0] kb_data;
  logic       kb_ack;
  logic       kb_err;
  logic       clr_req;
  logic [9:0] clr_fill;
  logic       clr_busy;
  logic       clr_done;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [9:0] mem_wr_data;
  logic [9:0] mem_rd_data;

  always #5 clk = ~clk;

  text_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .vga_rd_en    (vga_rd_en),
    .vga_rd_addr  (vga_rd_addr),
    .vga_rd_data  (vga_rd_data),
    .vga_rd_valid (vga_rd_valid),
    .kb_req       (kb_req),
    .kb_addr      (kb_addr),
    .kb_data      (kb_data),
    .kb_ack       (kb_ack),
    .kb_err       (kb_err),
    .clr_req      (clr_req),
`ifdef TEXT_MEM_ARB_FILL_EN
    .clr_fill     (clr_fill),
`endif
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data)
  );

  // Synchronous single-port RAM with a known initial image.
  logic [9:0] ram [1024];
  logic       ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 10'(i * 37 + 5);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= ram[mem_addr];
  end

  // Reference model state.
  int m_mem [1024];
  bit m_clearing;
  int m_idx;
  int m_fill;
  bit m_done;
  bit m_vpend;
  int m_vdata;

  int n_checks;
  int n_fail;
  int cyc;
  bit last_ack;
  int done_cnt;
  int done_cyc;
  int ack_cyc;
  int we_cnt;
  int c0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    bit e_we;
    bit e_ack;
    bit e_err;
    int e_addr;
    int e_data;
    e_we   = 1'b0;
    e_ack  = 1'b0;
    e_err  = 1'b0;
    e_addr = 0;
    e_data = 0;
    @(negedge clk);
    if (vga_rd_en) begin
      e_addr = int'(vga_rd_addr);
    end else if (m_clearing) begin
      e_we   = 1'b1;
      e_addr = m_idx;
      e_data = m_fill;
    end else if (kb_req) begin
      e_ack  = 1'b1;
      e_err  = (int'(kb_addr) >= CELLS);
      e_we   = !e_err;
      e_addr = int'(kb_addr);
      e_data = int'(kb_data);
    end
    check_eq("mem_we", int'(mem_we), int'(e_we));
    if (e_we || vga_rd_en) check_eq("mem_addr", int'(mem_addr), e_addr);
    if (e_we) check_eq("mem_wr_data", int'(mem_wr_data), e_data);
    check_eq("kb_ack", int'(kb_ack), int'(e_ack));
    check_eq("kb_err", int'(kb_err), int'(e_err));
    check_eq("clr_busy", int'(clr_busy), int'(m_clearing));
    check_eq("clr_done", int'(clr_done), int'(m_done));
    check_eq("vga_rd_valid", int'(vga_rd_valid), int'(m_vpend));
    if (m_vpend) check_eq("vga_rd_data", int'(vga_rd_data), m_vdata);
    if (clr_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (kb_ack) ack_cyc = cyc;
    if (mem_we) we_cnt++;
    last_ack = e_ack;
    @(posedge clk);
    if (e_we) m_mem[e_addr] = e_data;
    if (rst) begin
      m_clearing = 1'b0;
      m_idx      = 0;
      m_done     = 1'b0;
      m_vpend    = 1'b0;
    end else begin
      m_done  = 1'b0;
      m_vpend = vga_rd_en;
      if (vga_rd_en) m_vdata = m_mem[vga_rd_addr];
      if (m_clearing) begin
        if (!vga_rd_en) begin
          if (m_idx == CELLS - 1) begin
            m_clearing = 1'b0;
            m_idx      = 0;
            m_done     = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else if (clr_req) begin
        m_clearing = 1'b1;
        m_idx      = 0;
`ifdef TEXT_MEM_ARB_FILL_EN
        m_fill     = int'(clr_fill);
`else
        m_fill     = 0;
`endif
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    ack_cyc     = -1;
    we_cnt      = 0;
    last_ack    = 1'b0;
    m_clearing  = 1'b0;
    m_idx       = 0;
    m_fill      = 0;
    m_done      = 1'b0;
    m_vpend     = 1'b0;
    m_vdata     = 0;
    for (int i = 0; i < 1024; i++) m_mem[i] = (i * 37 + 5) % 1024;
    rst         = 1'b1;
    ram_init    = 1'b1;
    vga_rd_en   = 1'b0;
    vga_rd_addr = '0;
    kb_req      = 1'b0;
    kb_addr     = '0;
    kb_data     = '0;
    clr_req     = 1'b0;
    clr_fill    = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    @(negedge clk);
    check_eq("rst_clr_busy", int'(clr_busy), 0);
    check_eq("rst_clr_done", int'(clr_done), 0);
    check_eq("rst_kb_ack", int'(kb_ack), 0);
    check_eq("rst_kb_err", int'(kb_err), 0);
    check_eq("rst_vga_valid", int'(vga_rd_valid), 0);
    check_eq("rst_mem_we", int'(mem_we), 0);
    check_eq("rst_mem_addr", int'(mem_addr), 0);
    check_eq("rst_mem_wr_data", int'(mem_wr_data), 0);
    check_eq("rst_vga_data", int'(vga_rd_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain keyboard write.
    kb_req  = 1'b1;
    kb_addr = 10'd5;
    kb_data = 10'h01A;
    tick();
    check_eq("kb5_ack_seen", ack_cyc, cyc - 1);
    kb_req = 1'b0;
    tick();

    // Keyboard collides with VGA, then goes through next cycle.
    kb_req      = 1'b1;
    kb_addr     = 10'd3;
    kb_data     = 10'h2B;
    vga_rd_en   = 1'b1;
    vga_rd_addr = 10'd7;
    tick();
    vga_rd_en = 1'b0;
    tick();
    kb_req = 1'b0;
    tick();

    // Full sweep with no VGA traffic.
    clr_req = 1'b1;
    c0      = cyc;
    tick();
    clr_req  = 1'b0;
    done_cnt = 0;
    we_cnt   = 0;
    for (int i = 0; i < 700 && done_cnt == 0; i++) tick();
    check_eq("clr_latency", done_cyc - c0, 601);
    check_eq("clr_writes", we_cnt, 600);
    repeat (3) tick();
    check_eq("clr_done_once", done_cnt, 1);

    // Sweep interleaved with VGA every other cycle.
    clr_req = 1'b1;
    c0      = cyc;
    tick();
    clr_req  = 1'b0;
    done_cnt = 0;
    we_cnt   = 0;
    for (int i = 0; i < 1300 && done_cnt == 0; i++) begin
      vga_rd_en   = (i % 2 == 0);
      vga_rd_addr = 10'($urandom_range(CELLS - 1));
      tick();
    end
    vga_rd_en = 1'b0;
    check_eq("clr_vga_latency", done_cyc - c0, 1201);
    check_eq("clr_vga_writes", we_cnt, 600);
    tick();

    // Keyboard request held across a sweep.
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    kb_req   = 1'b1;
    kb_addr  = 10'd9;
    kb_data  = 10'h3C;
    ack_cyc  = -1;
    done_cnt = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (last_ack) break;
    end
    kb_req = 1'b0;
    check_eq("kb_after_clear", ack_cyc, done_cyc);
    tick();

    // Out-of-range keyboard addresses.
    kb_req  = 1'b1;
    kb_addr = 10'd600;
    kb_data = 10'h155;
    tick();
    kb_req = 1'b0;
    tick();
    kb_req  = 1'b1;
    kb_addr = 10'd1023;
    tick();
    kb_req = 1'b0;
    tick();

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (300) tick();
    rst      = 1'b1;
    done_cnt = 0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check_eq("rst_no_done", done_cnt, 0);
    vga_rd_en   = 1'b1;
    vga_rd_addr = 10'd450;
    tick();
    vga_rd_addr = 10'd0;
    tick();
    vga_rd_en = 1'b0;
    tick();

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      vga_rd_en   = ($urandom_range(1) == 0);
      vga_rd_addr = 10'($urandom_range(CELLS - 1));
      clr_req     = ($urandom_range(299) == 0);
      clr_fill    = 10'($urandom);
      rst         = ($urandom_range(999) == 0);
      if (kb_req && last_ack) begin
        kb_req = 1'b0;
      end else if (!kb_req && $urandom_range(3) == 0) begin
        kb_req  = 1'b1;
        kb_addr = ($urandom_range(15) == 0) ? 10'($urandom_range(1023, 600))
                                            : 10'($urandom_range(CELLS - 1));
        kb_data = 10'($urandom);
      end
      tick();
    end
    vga_rd_en = 1'b0;
    clr_req   = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 1300 && kb_req; i++) begin
      tick();
      if (last_ack) kb_req = 1'b0;
    end
    tick();

    // Read back the whole screen through the VGA path.
    for (int a = 0; a < CELLS; a++) begin
      vga_rd_en   = 1'b1;
      vga_rd_addr = 10'(a);
      tick();
    end
    vga_rd_en = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_mem_arbiter.md
Name: text_mem_arbiter

Overview:
- Single owner of the port of the single-port 40x15 character RAM (600 cells).
- Shares the port between three requesters:
  - the VGA character fetch, which only reads;
  - the keyboard writer, which writes characters;
  - an internal clear engine that sweeps every cell to the fill value.
- Sits between the keyboard-to-text logic, the VGA text renderer and the character RAM.
- Replaces ad-hoc clear-by-counter stepping with a proper sequenced sweep.

Parameters:
- COLS, 40, characters per line.
- ROWS, 15, lines per screen.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- DATA_W, 10, character code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- vga_rd_en  in  1  VGA fetch request this cycle.
- vga_rd_addr  in  ADDR_W  VGA fetch address.
- vga_rd_data  out  DATA_W  fetched character.
- vga_rd_valid  out  1  vga_rd_data valid.
- kb_req  in  1  keyboard write request; level, held until ack.
- kb_addr  in  ADDR_W  keyboard write address.
- kb_data  in  DATA_W  keyboard write data.
- kb_ack  out  1  one-cycle pulse; the write was issued or dropped.
- kb_err  out  1  one-cycle pulse with kb_ack when kb_addr >= COLS*ROWS.
- clr_req  in  1  single-cycle pulse; start a screen clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse after the last cell is written.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wr_data  out  DATA_W  RAM write data.
- mem_rd_data  in  DATA_W  RAM read data; synchronous, 1-cycle latency.

Behaviour:
- Reset values:
  - FSM is IDLE; clear counter is 0.
  - clr_busy, clr_done, kb_ack, kb_err, vga_rd_valid and mem_we are all 0.
  - mem_addr, mem_wr_data and vga_rd_data are 0.
- mem_addr, mem_we, mem_wr_data, kb_ack and kb_err are combinational from the FSM state, the counter and the request inputs.
- Fixed per-cycle priority: VGA > clear > keyboard. One grant per cycle.
- VGA grant:
  - mem_addr = vga_rd_addr, mem_we = 0.
  - vga_rd_valid is registered: it goes high the cycle after the grant, and vga_rd_data is registered from mem_rd_data.
  - VGA is never stalled.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req. The counter loads 0 and clr_busy goes to 1 on the next edge.
  - In CLEAR, each cycle without vga_rd_en writes the fill value to the counter address, then increments the counter.
  - A VGA cycle holds the counter.
  - After writing address COLS*ROWS-1: go to IDLE, counter returns to 0, clr_done pulses in the following cycle, clr_busy goes to 0.
- clr_req while in CLEAR is ignored; the sweep does not restart.
- Keyboard writes:
  - Granted only in IDLE with no vga_rd_en. Grant: mem_we = 1, mem_addr = kb_addr, mem_wr_data = kb_data, kb_ack = 1.
  - During CLEAR, kb_req stalls: no ack is given and the request is not lost.
  - kb_req must deassert the cycle after kb_ack. A still-high kb_req is treated as a new request.
  - Out-of-range kb_addr (>= COLS*ROWS): kb_ack = 1, kb_err = 1, mem_we = 0.
- Same-cycle clr_req and kb_req in IDLE: keyboard wins that cycle; the clear starts on the next edge.
- rst mid-sweep aborts to IDLE with no clr_done. Cells not yet swept keep their contents.
- Counter width is ADDR_W; it never reaches or exceeds COLS*ROWS.

Optional Feature:
- Macro: TEXT_MEM_ARB_FILL_EN.
- Defined: adds input port clr_fill [DATA_W-1:0]. It is sampled on the clr_req cycle into a register, and that register is the sweep write value.
- Undefined: no clr_fill port; the sweep writes 0.

Decomposition:
- Shared package text_mem_pkg holds:
  - constants TXT_COLS = 40, TXT_ROWS = 15, TXT_CELLS = 600, TXT_ADDR_W = 10, TXT_DATA_W = 10;
  - typedef enum logic {ARB_IDLE, ARB_CLEAR} arb_state_t;
  - typedef txt_addr_t.
- One natural sub-module: text_clear_engine, holding the counter, clr_busy, clr_done and the fill register.
- The arbiter top holds priority muxing, keyboard handshake and the VGA read register.

Test Plan:
- Reset, then kb_req with addr 5, data 10'h01A and no VGA -> same cycle: mem_we = 1, mem_addr = 5, mem_wr_data = 10'h01A, kb_ack = 1.
- kb_req and vga_rd_en in the same cycle (kb addr 3, VGA addr 7) -> VGA gets mem_addr 7 with mem_we = 0 and no ack. Next cycle (vga_rd_en low): kb write to addr 3 with ack, and vga_rd_valid = 1.
- clr_req with vga_rd_en low throughout -> 600 consecutive writes of 0 to addresses 0..599. clr_done pulses exactly once, 601 cycles after clr_req; clr_busy is low afterwards.
- clr_req, then vga_rd_en every other cycle -> every address 0..599 is written exactly once, in order, and the sweep takes 1200 cycles.
- kb_req held during a sweep -> no kb_ack until the cycle after clr_busy falls, then a single write.
- kb_addr = 600 -> kb_ack = 1, kb_err = 1, mem_we = 0.
- rst asserted at counter 300 -> next cycle clr_busy = 0, counter 0, and no clr_done.
